// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl
// Sequences one PRBS burst: takes a seed/length/count request over a
// valid/ready handshake, rejects requests whose seed is zero within the
// active stages or whose count is zero, loads the generator, enables it for
// exactly Count cycles, and forwards every generated bit while counting ones.
module prbs_burst_ctrl #(
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Cfg_Valid,
    output logic             Cfg_Ready,
    input  logic [29:0]      Cfg_Semilla,
    input  logic [1:0]       Cfg_Longitud,
    input  logic [CNT_W-1:0] Cfg_Count,
    input  logic             Abort,
    output logic             Prbs_Load,
    output logic [29:0]      Prbs_Semilla,
    output logic [1:0]       Prbs_Longitud,
    output logic             Prbs_En,
    input  logic             Prbs_Bit,
    output logic             Bit_Valid,
    output logic             Bit_Out,
    output logic             Done,
    output logic             Error,
    output logic             Busy,
    output logic [CNT_W-1:0] Ones_Count
);

    // Settle counter only needs to hold SETTLE_CYC-1; keep at least one bit
    // so the declaration stays legal when no settle phase is configured.
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        (SETTLE_CYC > 0) ? SET_W'(SETTLE_CYC - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [CNT_W-1:0]   run_cnt_reg;
    logic [SET_W-1:0]   settle_cnt_reg;
    logic [29:0]        semilla_reg;
    logic [1:0]         longitud_reg;
    logic               bit_valid_reg;
    logic               bit_out_reg;
    logic               error_reg;
    logic [CNT_W-1:0]   ones_reg;

    logic [29:0]        seed_mask;
    logic               cfg_ok;
    logic               accept;

    // Active-stage mask per length code: the low 6 stages are always in use,
    // stages 6..24 only for the 25/30-stage codes, 25..29 only for 30-stage.
    genvar gi;
    generate
        for (gi = 0; gi < 30; gi++) begin : g_mask
            if (gi < 6) begin : g_lo
                assign seed_mask[gi] = 1'b1;
            end else if (gi < 25) begin : g_mid
                assign seed_mask[gi] = ~Cfg_Longitud[1];
            end else begin : g_hi
                assign seed_mask[gi] = (Cfg_Longitud == 2'b00);
            end
        end
    endgenerate

    assign cfg_ok = (|(Cfg_Semilla & seed_mask)) && (Cfg_Count != '0);
    assign accept = Cfg_Valid && (state_reg == ST_IDLE);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        state_next = state_reg;
        Cfg_Ready  = 1'b0;
        Prbs_Load  = 1'b0;
        Prbs_En    = 1'b0;
        Done       = 1'b0;
        Busy       = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                Cfg_Ready = 1'b1;
                Busy      = 1'b0;
                if (accept && cfg_ok) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                Prbs_Load = 1'b1;
                if (Abort) begin
                    state_next = ST_IDLE;
                end else if (SETTLE_CYC > 0) begin
                    state_next = ST_SETTLE;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (Abort) begin
                    state_next = ST_IDLE;
                end else if (settle_cnt_reg == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // The aborting cycle still shifts; its bit is forwarded.
                Prbs_En = 1'b1;
                if (Abort) begin
                    state_next = ST_IDLE;
                end else if (run_cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                Done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Burst length and settle down-counters.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
        end else begin
            if (accept) begin
                run_cnt_reg <= Cfg_Count;
            end else if (state_reg == ST_RUN) begin
                run_cnt_reg <= run_cnt_reg - CNT_W'(1);
            end
            if (state_reg == ST_LOAD) begin
                settle_cnt_reg <= SETTLE_LOAD;
            end else if (state_reg == ST_SETTLE && settle_cnt_reg != '0) begin
                settle_cnt_reg <= settle_cnt_reg - SET_W'(1);
            end
        end
    end

    // Config capture, reject strobe and bit forwarding / ones counting.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            semilla_reg   <= '0;
            longitud_reg  <= '0;
            error_reg     <= 1'b0;
            bit_valid_reg <= 1'b0;
            bit_out_reg   <= 1'b0;
            ones_reg      <= '0;
        end else begin
            error_reg     <= accept && !cfg_ok;
            bit_valid_reg <= Prbs_En;
            if (accept) begin
                // Captured even when rejected; ones count restarts per request.
                semilla_reg  <= Cfg_Semilla;
                longitud_reg <= Cfg_Longitud;
                ones_reg     <= '0;
            end else if (Prbs_En) begin
                bit_out_reg <= Prbs_Bit;
                ones_reg    <= ones_reg + {{(CNT_W-1){1'b0}}, Prbs_Bit};
            end
        end
    end

    assign Prbs_Semilla  = semilla_reg;
    assign Prbs_Longitud = longitud_reg;
    assign Bit_Valid     = bit_valid_reg;
    assign Bit_Out       = bit_out_reg;
    assign Error         = error_reg;
    assign Ones_Count    = ones_reg;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl
// Directed bench for prbs_burst_ctrl: the bench itself plays the PRBS
// generator by driving Prbs_Bit from fixed patterns, so expected bit values
// and ones counts are known up front.
module tb_prbs_burst_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Cfg_Valid;
    logic        Cfg_Ready;
    logic [29:0] Cfg_Semilla;
    logic [1:0]  Cfg_Longitud;
    logic [15:0] Cfg_Count;
    logic        Abort;
    logic        Prbs_Load;
    logic [29:0] Prbs_Semilla;
    logic [1:0]  Prbs_Longitud;
    logic        Prbs_En;
    logic        Prbs_Bit;
    logic        Bit_Valid;
    logic        Bit_Out;
    logic        Done;
    logic        Error;
    logic        Busy;
    logic [15:0] Ones_Count;

    int errors = 0;
    int checks = 0;

    prbs_burst_ctrl #(
        .CNT_W      (16),
        .SETTLE_CYC (0)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Cfg_Valid     (Cfg_Valid),
        .Cfg_Ready     (Cfg_Ready),
        .Cfg_Semilla   (Cfg_Semilla),
        .Cfg_Longitud  (Cfg_Longitud),
        .Cfg_Count     (Cfg_Count),
        .Abort         (Abort),
        .Prbs_Load     (Prbs_Load),
        .Prbs_Semilla  (Prbs_Semilla),
        .Prbs_Longitud (Prbs_Longitud),
        .Prbs_En       (Prbs_En),
        .Prbs_Bit      (Prbs_Bit),
        .Bit_Valid     (Bit_Valid),
        .Bit_Out       (Bit_Out),
        .Done          (Done),
        .Error         (Error),
        .Busy          (Busy),
        .Ones_Count    (Ones_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] pat1;
    logic [2:0] pat5;
    int         valid_cnt;

    initial begin
        Reset        = 1'b0;
        Cfg_Valid    = 1'b0;
        Cfg_Semilla  = '0;
        Cfg_Longitud = '0;
        Cfg_Count    = '0;
        Abort        = 1'b0;
        Prbs_Bit     = 1'b0;
        repeat (2) tick();

        // ---- reset state ----
        chk("rst_ready",  32'(Cfg_Ready),    32'd1);
        chk("rst_busy",   32'(Busy),         32'd0);
        chk("rst_load",   32'(Prbs_Load),    32'd0);
        chk("rst_en",     32'(Prbs_En),      32'd0);
        chk("rst_bv",     32'(Bit_Valid),    32'd0);
        chk("rst_done",   32'(Done),         32'd0);
        chk("rst_err",    32'(Error),        32'd0);
        chk("rst_ones",   32'(Ones_Count),   32'd0);
        chk("rst_sem",    32'(Prbs_Semilla), 32'd0);
        Reset = 1'b1;
        tick();

        // ---- 1: 6-stage, seed 1, count 4, bits 1,0,1,1 ----
        pat1         = 4'b1101;
        Cfg_Longitud = 2'b10;
        Cfg_Semilla  = 30'h1;
        Cfg_Count    = 16'd4;
        Cfg_Valid    = 1'b1;
        chk("t1_ready_pre", 32'(Cfg_Ready), 32'd1);
        tick();                                   // T+1
        Cfg_Valid = 1'b0;
        chk("t1_load",  32'(Prbs_Load),     32'd1);
        chk("t1_en0",   32'(Prbs_En),       32'd0);
        chk("t1_busy",  32'(Busy),          32'd1);
        chk("t1_rdy0",  32'(Cfg_Ready),     32'd0);
        chk("t1_err",   32'(Error),         32'd0);
        chk("t1_sem",   32'(Prbs_Semilla),  32'h1);
        chk("t1_lon",   32'(Prbs_Longitud), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();                               // T+2+i
            chk("t1_en",   32'(Prbs_En),   32'd1);
            chk("t1_load0", 32'(Prbs_Load), 32'd0);
            chk("t1_done0", 32'(Done),      32'd0);
            chk("t1_bv",   32'(Bit_Valid), 32'(i > 0));
            if (i > 0) chk("t1_bo", 32'(Bit_Out), 32'(pat1[i-1]));
            Prbs_Bit = pat1[i];
        end
        tick();                                   // T+6
        chk("t1_done",  32'(Done),       32'd1);
        chk("t1_bv_l",  32'(Bit_Valid),  32'd1);
        chk("t1_bo_l",  32'(Bit_Out),    32'(pat1[3]));
        chk("t1_ones",  32'(Ones_Count), 32'd3);
        chk("t1_en_off", 32'(Prbs_En),   32'd0);
        tick();                                   // T+7
        chk("t1_ready", 32'(Cfg_Ready),  32'd1);
        chk("t1_busy0", 32'(Busy),       32'd0);
        chk("t1_done1", 32'(Done),       32'd0);
        chk("t1_bv0",   32'(Bit_Valid),  32'd0);
        chk("t1_hold",  32'(Ones_Count), 32'd3);
        $display("burst 1: len=10 seed=1 count=4 ones=%0d", Ones_Count);

        // ---- 2: 6-stage, only bit 10 set -> reject ----
        Cfg_Longitud = 2'b10;
        Cfg_Semilla  = 30'h400;
        Cfg_Count    = 16'd5;
        Cfg_Valid    = 1'b1;
        tick();                                   // T+1
        Cfg_Valid = 1'b0;
        chk("t2_err",   32'(Error),        32'd1);
        chk("t2_load",  32'(Prbs_Load),    32'd0);
        chk("t2_busy",  32'(Busy),         32'd0);
        chk("t2_ready", 32'(Cfg_Ready),    32'd1);
        chk("t2_sem",   32'(Prbs_Semilla), 32'h400);
        chk("t2_ones",  32'(Ones_Count),   32'd0);
        tick();
        chk("t2_err0",  32'(Error),        32'd0);
        chk("t2_load0", 32'(Prbs_Load),    32'd0);
        chk("t2_en0",   32'(Prbs_En),      32'd0);
        chk("t2_busy0", 32'(Busy),         32'd0);
        $display("burst 2: len=10 seed=400 rejected err=0");

        // ---- 3: 30-stage, all-ones seed, count 0 -> reject ----
        Cfg_Longitud = 2'b00;
        Cfg_Semilla  = 30'h3FFFFFFF;
        Cfg_Count    = 16'd0;
        Cfg_Valid    = 1'b1;
        tick();
        Cfg_Valid = 1'b0;
        chk("t3_err",  32'(Error),     32'd1);
        chk("t3_load", 32'(Prbs_Load), 32'd0);
        chk("t3_busy", 32'(Busy),      32'd0);
        tick();
        chk("t3_err0", 32'(Error),     32'd0);
        chk("t3_load0", 32'(Prbs_Load), 32'd0);
        $display("burst 3: len=00 count=0 rejected");

        // ---- 4: 25-stage, count 100, abort in 10th enable cycle ----
        Cfg_Longitud = 2'b01;
        Cfg_Semilla  = 30'h0123456;
        Cfg_Count    = 16'd100;
        Cfg_Valid    = 1'b1;
        tick();                                   // T+1
        Cfg_Valid = 1'b0;
        valid_cnt = 0;
        chk("t4_load", 32'(Prbs_Load), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t4_en", 32'(Prbs_En), 32'd1);
            if (Bit_Valid) valid_cnt++;
            Prbs_Bit = ((k % 3) == 0) || (k == 10);
            if (k == 10) Abort = 1'b1;
        end
        tick();
        if (Bit_Valid) valid_cnt++;
        Abort = 1'b0;
        chk("t4_busy0",  32'(Busy),       32'd0);
        chk("t4_ready",  32'(Cfg_Ready),  32'd1);
        chk("t4_en0",    32'(Prbs_En),    32'd0);
        chk("t4_done0",  32'(Done),       32'd0);
        chk("t4_err0",   32'(Error),      32'd0);
        chk("t4_bv_l",   32'(Bit_Valid),  32'd1);
        chk("t4_ones",   32'(Ones_Count), 32'd4);
        tick();
        chk("t4_bv0",    32'(Bit_Valid),  32'd0);
        chk("t4_done1",  32'(Done),       32'd0);
        chk("t4_hold",   32'(Ones_Count), 32'd4);
        chk("t4_nvalid", 32'(valid_cnt),  32'd10);
        $display("burst 4: len=01 count=100 aborted valids=%0d ones=%0d", valid_cnt, Ones_Count);

        // ---- 5: Cfg_Valid held, two count-3 bursts back to back ----
        Cfg_Longitud = 2'b10;
        Cfg_Semilla  = 30'h2A;
        Cfg_Count    = 16'd3;
        Cfg_Valid    = 1'b1;
        Prbs_Bit     = 1'b1;
        tick();                                   // T+1
        chk("t5_load_a", 32'(Prbs_Load), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_en_a", 32'(Prbs_En), 32'd1);
        end
        tick();                                   // T+5
        chk("t5_done_a", 32'(Done),       32'd1);
        chk("t5_ones_a", 32'(Ones_Count), 32'd3);
        tick();                                   // T+6
        chk("t5_rdy",    32'(Cfg_Ready),  32'd1);
        chk("t5_done_x", 32'(Done),       32'd0);
        chk("t5_hold",   32'(Ones_Count), 32'd3);
        $display("burst 5a: len=10 count=3 ones=%0d", Ones_Count);
        tick();                                   // T+7
        Cfg_Valid = 1'b0;
        chk("t5_load_b", 32'(Prbs_Load),  32'd1);
        chk("t5_clr",    32'(Ones_Count), 32'd0);
        pat5 = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_en_b", 32'(Prbs_En), 32'd1);
            Prbs_Bit = pat5[i];
        end
        tick();
        chk("t5_done_b", 32'(Done),       32'd1);
        chk("t5_ones_b", 32'(Ones_Count), 32'd1);
        tick();
        chk("t5_rdy_b",  32'(Cfg_Ready),  32'd1);
        $display("burst 5b: len=10 count=3 ones=%0d", Ones_Count);

        // ---- 6: reset in the middle of a count-50 burst ----
        Cfg_Longitud = 2'b00;
        Cfg_Semilla  = 30'h1;
        Cfg_Count    = 16'd50;
        Cfg_Valid    = 1'b1;
        tick();                                   // T+1
        Cfg_Valid = 1'b0;
        Prbs_Bit  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_en", 32'(Prbs_En), 32'd1);
        end
        chk("t6_ones_pre", 32'(Ones_Count), 32'd4);
        Reset = 1'b0;
        tick();
        chk("t6_busy",  32'(Busy),          32'd0);
        chk("t6_ready", 32'(Cfg_Ready),     32'd1);
        chk("t6_en0",   32'(Prbs_En),       32'd0);
        chk("t6_load",  32'(Prbs_Load),     32'd0);
        chk("t6_bv",    32'(Bit_Valid),     32'd0);
        chk("t6_bo",    32'(Bit_Out),       32'd0);
        chk("t6_done",  32'(Done),          32'd0);
        chk("t6_err",   32'(Error),         32'd0);
        chk("t6_ones",  32'(Ones_Count),    32'd0);
        chk("t6_sem",   32'(Prbs_Semilla),  32'd0);
        chk("t6_lon",   32'(Prbs_Longitud), 32'd0);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_quiet_done", 32'(Done), 32'd0);
            chk("t6_quiet_busy", 32'(Busy), 32'd0);
        end
        $display("burst 6: count=50 interrupted by reset");
        Cfg_Longitud = 2'b10;
        Cfg_Semilla  = 30'h3;
        Cfg_Count    = 16'd2;
        Cfg_Valid    = 1'b1;
        tick();                                   // T+1
        Cfg_Valid = 1'b0;
        chk("t6b_load", 32'(Prbs_Load), 32'd1);
        tick();
        chk("t6b_en1",  32'(Prbs_En),   32'd1);
        tick();
        chk("t6b_en2",  32'(Prbs_En),   32'd1);
        tick();
        chk("t6b_done", 32'(Done),       32'd1);
        chk("t6b_ones", 32'(Ones_Count), 32'd2);
        tick();
        chk("t6b_rdy",  32'(Cfg_Ready),  32'd1);
        $display("burst 7: len=10 seed=3 count=2 ones=%0d", Ones_Count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
